// File: rtl/ps2_pkg.sv
// Shared constants, receiver state encoding and the frame-check helper for
// the PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_JUMP  = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_SHOOT = 3;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return (^data ^ parity) & stop;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, 11-bit frame
// FSM with parity/stop check and an inactivity watchdog.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [7:0]             scan_code_q, scan_code_d;
  logic                   scan_valid_q, scan_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d   = clk_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == RX_IDLE || fall) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (fall && !data_s) begin
          state_d   = RX_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          if (frame_ok(shift_q, parity_q, data_s)) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A falling edge on the terminal count keeps the frame alive.
    if (state_q != RX_IDLE && !fall && wd_q == WD_LAST) begin
      state_d     = RX_IDLE;
      frame_err_d = 1'b1;
      wd_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      wd_q         <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_q         <= wd_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
    shift_q  <= shift_d;
    parity_q <= parity_d;
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives scan codes and tracks the held state of
// the four game keys, honouring E0 (extended) and F0 (break) prefixes.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 20000,
  parameter logic [7:0] SC_JUMP        = 8'h12,
  parameter logic [7:0] SC_LEFT        = 8'h6B,
  parameter logic [7:0] SC_RIGHT       = 8'h74,
  parameter logic [7:0] SC_SHOOT       = 8'h1A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keys,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic [7:0] rx_code;
  logic       rx_valid;
  logic       rx_err;

  logic [3:0] keys_q, keys_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (rx_code),
    .scan_valid(rx_valid),
    .frame_err (rx_err)
  );

  always_comb begin
    keys_d = keys_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    // A rejected frame may have been the key the pending prefix belonged to.
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_code == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_code == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (!ext_q && rx_code == SC_JUMP)  keys_d[KEY_JUMP]  = ~brk_q;
        if (ext_q  && rx_code == SC_LEFT)  keys_d[KEY_LEFT]  = ~brk_q;
        if (ext_q  && rx_code == SC_RIGHT) keys_d[KEY_RIGHT] = ~brk_q;
        if (!ext_q && rx_code == SC_SHOOT) keys_d[KEY_SHOOT] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= 4'b0000;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
    end
  end

  assign keys       = keys_q;
  assign scan_code  = rx_code;
  assign scan_valid = rx_valid;
  assign frame_err  = rx_err;

endmodule
